// File: rtl/instr_sequencer_if.sv
// Datapath-facing bus of the instruction sequencer: fetched word and flags in, instruction register and control strobes out.
interface instr_sequencer_if;
  logic [31:0] fetch_data;
  logic [3:0]  flags_in;
  logic [31:0] instr;
  logic        pc_flag;
  logic        sel_add;
  logic        ram_rw;
  logic        sel_ldr;
  logic        reg_we;
  logic        flags_we;

  modport master (
    input  fetch_data, flags_in,
    output instr, pc_flag, sel_add, ram_rw, sel_ldr, reg_we, flags_we
  );

  modport slave (
    output fetch_data, flags_in,
    input  instr, pc_flag, sel_add, ram_rw, sel_ldr, reg_we, flags_we
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/condition/execute/memory/writeback sequencer for the 32-bit datapath.
// Optional SEQ_STEP_EN adds a step input: each instruction then needs run=1 and step=1 and always ends in IDLE.
module instr_sequencer #(
  parameter int unsigned MEM_LAT = 1,
  parameter logic [3:0]  LDR_OP  = 4'hE,
  parameter logic [3:0]  STR_OP  = 4'hF,
  parameter logic [3:0]  HALT_OP = 4'hD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
`ifdef SEQ_STEP_EN
  input  logic               step,
`endif
  instr_sequencer_if.master  bus,
  output logic               halted,
  output logic [15:0]        instr_count
);
  localparam int unsigned     CNT_W     = 4;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] wait_cnt, wait_d;
  logic [31:0]      instr_d;
  logic             cond_ok, cond_d;
  logic             pc_flag_d, sel_add_d, ram_rw_d, sel_ldr_d, reg_we_d, flags_we_d, halted_d;
  logic [3:0]       opcode;
  logic             is_ldr, is_str, is_halt;
  logic             leave_idle, end_to_fetch;

  assign opcode  = bus.instr[27:24];
  assign is_ldr  = (opcode == LDR_OP);
  assign is_str  = (opcode == STR_OP);
  assign is_halt = (opcode == HALT_OP);

`ifdef SEQ_STEP_EN
  assign leave_idle   = run & step;
  assign end_to_fetch = 1'b0;
`else
  assign leave_idle   = run;
  assign end_to_fetch = run;
`endif

  // Condition code table over {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = ~c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = c & ~z;
      4'h9:    cond_pass = ~c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Next state, and next-cycle strobes decoded from the state being entered so outputs stay registered.
  always_comb begin
    state_d = state;
    wait_d  = wait_cnt;
    instr_d = bus.instr;
    cond_d  = cond_ok;
    case (state)
      S_IDLE: if (leave_idle) begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: if (wait_cnt == LAST_WAIT) begin
        state_d = S_DECODE;
        wait_d  = '0;
        instr_d = bus.fetch_data;
        cond_d  = cond_pass(bus.fetch_data[31:28], bus.flags_in);
      end else begin
        wait_d = wait_cnt + CNT_W'(1);
      end
      S_DECODE:    state_d = cond_ok ? S_EXECUTE : (end_to_fetch ? S_FETCH : S_IDLE);
      S_EXECUTE:   state_d = is_halt ? S_HALT : ((is_ldr | is_str) ? S_MEM : S_WRITEBACK);
      S_MEM: if (wait_cnt == LAST_WAIT) begin
        state_d = is_str ? (end_to_fetch ? S_FETCH : S_IDLE) : S_WRITEBACK;
        wait_d  = '0;
      end else begin
        wait_d = wait_cnt + CNT_W'(1);
      end
      S_WRITEBACK: state_d = end_to_fetch ? S_FETCH : S_IDLE;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase

    sel_add_d  = (state_d == S_MEM);
    ram_rw_d   = (state_d == S_MEM) & is_str;
    reg_we_d   = (state_d == S_WRITEBACK);
    sel_ldr_d  = (state_d == S_WRITEBACK) & is_ldr;
    flags_we_d = (state_d == S_EXECUTE) & ~(is_ldr | is_str | is_halt) & bus.instr[23];
    halted_d   = (state_d == S_HALT);
    pc_flag_d  = ((state_d == S_DECODE) & ~cond_d)
               | (state_d == S_WRITEBACK)
               | ((state_d == S_MEM) & is_str & (wait_d == LAST_WAIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      cond_ok      <= 1'b0;
      bus.instr    <= '0;
      bus.pc_flag  <= 1'b0;
      bus.sel_add  <= 1'b0;
      bus.ram_rw   <= 1'b0;
      bus.sel_ldr  <= 1'b0;
      bus.reg_we   <= 1'b0;
      bus.flags_we <= 1'b0;
      halted       <= 1'b0;
      instr_count  <= '0;
    end else begin
      state        <= state_d;
      wait_cnt     <= wait_d;
      cond_ok      <= cond_d;
      bus.instr    <= instr_d;
      bus.pc_flag  <= pc_flag_d;
      bus.sel_add  <= sel_add_d;
      bus.ram_rw   <= ram_rw_d;
      bus.sel_ldr  <= sel_ldr_d;
      bus.reg_we   <= reg_we_d;
      bus.flags_we <= flags_we_d;
      halted       <= halted_d;
      // Retire count follows the pc_flag pulse by one cycle.
      if (bus.pc_flag) instr_count <= instr_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-cycle expected strobe vectors queued per instruction, popped each cycle.
module tb_instr_sequencer;
  localparam logic [3:0] LDR  = 4'hE;
  localparam logic [3:0] STR  = 4'hF;
  localparam logic [3:0] HALT = 4'hD;

  typedef struct packed {
    logic        halted;
    logic        pc_flag;
    logic        sel_add;
    logic        ram_rw;
    logic        sel_ldr;
    logic        reg_we;
    logic        flags_we;
    logic [15:0] count;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, run1, run3, step_tie;
  logic        halted1, halted3;
  logic [15:0] count1, count3;
  logic [15:0] mcount1, mcount3;
  int          checks = 0;
  int          errors = 0;
  obs_t        exp_q[$];

  instr_sequencer_if bus1 ();
  instr_sequencer_if bus3 ();

  instr_sequencer #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .run(run1),
`ifdef SEQ_STEP_EN
    .step(step_tie),
`endif
    .bus(bus1), .halted(halted1), .instr_count(count1)
  );

  instr_sequencer #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .run(run3),
`ifdef SEQ_STEP_EN
    .step(step_tie),
`endif
    .bus(bus3), .halted(halted3), .instr_count(count3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Queue the expected per-cycle outputs of one instruction starting at its first FETCH cycle; returns 1 if it retires.
  function automatic bit gen(input logic [31:0] w, input logic [3:0] f, input int lat, input logic [15:0] cnt);
    obs_t v;
    logic [3:0] op;
    op = w[27:24];
    v = '0;
    v.count = cnt;
    for (int i = 0; i < lat; i++) exp_q.push_back(v);
    if (!cond_ok(w[31:28], f)) begin
      v.pc_flag = 1'b1;
      exp_q.push_back(v);
      return 1'b1;
    end
    exp_q.push_back(v);
    v.flags_we = (op != LDR) && (op != STR) && (op != HALT) && w[23];
    exp_q.push_back(v);
    v.flags_we = 1'b0;
    if (op == HALT) begin
      v.halted = 1'b1;
      for (int i = 0; i < 20; i++) exp_q.push_back(v);
      return 1'b0;
    end
    if (op == LDR || op == STR) begin
      for (int i = 0; i < lat; i++) begin
        v.sel_add = 1'b1;
        v.ram_rw  = (op == STR);
        v.pc_flag = (op == STR) && (i == lat - 1);
        exp_q.push_back(v);
      end
      if (op == STR) return 1'b1;
    end
    v = '0;
    v.count   = cnt;
    v.reg_we  = 1'b1;
    v.sel_ldr = (op == LDR);
    v.pc_flag = 1'b1;
    exp_q.push_back(v);
    return 1'b1;
  endfunction

  function automatic obs_t sample(input int sel);
    if (sel == 1)
      return {halted1, bus1.pc_flag, bus1.sel_add, bus1.ram_rw, bus1.sel_ldr, bus1.reg_we, bus1.flags_we, count1};
    return {halted3, bus3.pc_flag, bus3.sel_add, bus3.ram_rw, bus3.sel_ldr, bus3.reg_we, bus3.flags_we, count3};
  endfunction

  function automatic obs_t idle_vec(input logic [15:0] cnt);
    obs_t v;
    v = '0;
    v.count = cnt;
    return v;
  endfunction

  task automatic check_obs(input string tag, input obs_t obs, input obs_t expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (halt,pc,sadd,rw,sldr,we,fwe,count)", tag, obs, expv);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one instruction into the selected DUT and compare every cycle; run drops after sample index drop_at.
  task automatic exec(input int sel, input logic [31:0] w, input logic [3:0] f, input int drop_at, input string tag);
    int idx;
    bit ret;
    idx = 0;
    if (sel == 1) begin
      bus1.fetch_data = w; bus1.flags_in = f;
      ret = gen(w, f, 1, mcount1);
    end else begin
      bus3.fetch_data = w; bus3.flags_in = f;
      ret = gen(w, f, 3, mcount3);
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check_obs($sformatf("%s[%0d]", tag, idx), sample(sel), exp_q.pop_front());
      if (idx == drop_at) begin
        if (sel == 1) run1 = 1'b0; else run3 = 1'b0;
      end
      idx++;
    end
    check32({tag, ".instr"}, (sel == 1) ? bus1.instr : bus3.instr, w);
    if (ret) begin
      if (sel == 1) mcount1 = mcount1 + 16'd1; else mcount3 = mcount3 + 16'd1;
    end
  endtask

  initial begin
    reset = 1'b1; run1 = 1'b0; run3 = 1'b0; step_tie = 1'b1;
    bus1.fetch_data = '0; bus1.flags_in = '0;
    bus3.fetch_data = '0; bus3.flags_in = '0;
    mcount1 = '0; mcount3 = '0;
    repeat (2) @(negedge clk);
    check_obs("reset1", sample(1), idle_vec(16'h0));
    check_obs("reset3", sample(3), idle_vec(16'h0));
    check32("reset_instr", bus1.instr, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run1 = 1'b1;
    exec(1, 32'hE1000000, 4'b0000, -1, "alu");
    exec(1, 32'hE1800000, 4'b0000, -1, "alu_s");
    exec(1, 32'h01000000, 4'b0000, -1, "eq_skip");
    exec(1, 32'h01000000, 4'b0100, -1, "eq_pass");
    for (int c = 0; c < 16; c++)
      exec(1, {4'(c), 4'h1, 24'h0}, 4'($urandom_range(0, 15)), -1, $sformatf("cond%0d", c));

    exec(1, 32'hE2000000, 4'b0000, 1, "drop");
    bus1.fetch_data = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_obs($sformatf("drop_idle[%0d]", i), sample(1), idle_vec(mcount1));
    end
    check32("drop_no_fetch", bus1.instr, 32'hE2000000);

    force dut1.instr_count = 16'hFFFF;
    @(negedge clk);
    release dut1.instr_count;
    mcount1 = 16'hFFFF;
    run1 = 1'b1;
    exec(1, 32'hE1000000, 4'b0000, 3, "wrap");
    @(negedge clk);
    check_obs("wrap_idle", sample(1), idle_vec(16'h0000));

    run1 = 1'b1;
    exec(1, 32'hED000000, 4'b0000, -1, "halt");
    run1 = 1'b0;

    run3 = 1'b1;
    exec(3, 32'hEE000000, 4'b0000, -1, "ldr3");
    exec(3, 32'hEF000000, 4'b0000, 7, "str3");
    @(negedge clk);
    check_obs("str3_idle", sample(3), idle_vec(mcount3));

    bus3.fetch_data = 32'hEF000000;
    run3 = 1'b1;
    repeat (6) @(negedge clk);
    check_obs("str_mem_before_reset", sample(3), {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mcount3});
    reset = 1'b1;
    #1;
    check_obs("reset_mid_mem", sample(3), idle_vec(16'h0));
    check32("reset_mid_mem_instr", bus3.instr, 32'h0);
    check_obs("reset_clears_halt", sample(1), idle_vec(16'h0));
    run3 = 1'b0;
    mcount3 = '0;
    @(negedge clk);
    reset = 1'b0;
    run3 = 1'b1;
    exec(3, 32'hE1800000, 4'b0000, 5, "after_reset");
    @(negedge clk);
    check_obs("after_reset_idle", sample(3), idle_vec(16'h1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
